// File: rtl/zoom_addr_gen_pkg.sv
// Zoom mode encodings and per-mode window geometry helpers.
// Combinational helpers only: no latency, no flow control.
package zoom_pkg;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 17;
  localparam int PIX_W   = 8;

  typedef enum logic [2:0] {
    MODE_IDENT = 3'b000,
    MODE_ZIN2  = 3'b001,
    MODE_ZIN4  = 3'b010,
    MODE_DEC2  = 3'b011,
    MODE_DEC4  = 3'b100
  } mode_e;

  function automatic mode_e decode_mode(input logic [2:0] sw);
    case (sw)
      3'b001:  return MODE_ZIN2;
      3'b010:  return MODE_ZIN4;
      3'b011:  return MODE_DEC2;
      3'b100:  return MODE_DEC4;
      default: return MODE_IDENT;
    endcase
  endfunction

  // log2 of the scale factor; IDENT is a zero shift in either direction
  function automatic logic [1:0] mode_shift(input mode_e m);
    case (m)
      MODE_ZIN2, MODE_DEC2: return 2'd1;
      MODE_ZIN4, MODE_DEC4: return 2'd2;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic mode_zoom_in(input mode_e m);
    return (m == MODE_ZIN2) || (m == MODE_ZIN4);
  endfunction

  function automatic int win_size(input int img, input mode_e m);
    if (mode_zoom_in(m)) return img << mode_shift(m);
    return img >> mode_shift(m);
  endfunction

  function automatic int win_origin(input int scr, input int img, input mode_e m);
    return (scr - win_size(img, m)) / 2;
  endfunction

endpackage

// File: rtl/zoom_addr_gen_if.sv
// Coordinate / ROM / colour bus between the VGA controller, the image ROM and zoom_addr_gen.
// master drives coordinates and ROM data; slave returns address, valid, colour and mode.
interface zoom_addr_gen_if;
  import zoom_pkg::*;

  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic [PIX_W-1:0]   mem_q;
  logic [ADDR_W-1:0]  address;
  logic               pix_valid;
  logic [PIX_W-1:0]   color_out;
  logic [2:0]         mode;

  modport master (
    output next_x, next_y, mem_q,
    input  address, pix_valid, color_out, mode
  );

  modport slave (
    input  next_x, next_y, mem_q,
    output address, pix_valid, color_out, mode
  );

endinterface

// File: rtl/zoom_addr_gen_axis_map.sv
// One axis: registers offset from window origin and in-window flag; scales the registered offset.
// 1 cycle to in_range/scaled; free-running, no backpressure.
module axis_map #(
  parameter int SCR = 640
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] coord,
  input  logic [9:0] origin,
  input  logic [10:0] size,
  input  logic [1:0] shift,
  input  logic       zoom_in,
  output logic       in_range,
  output logic [9:0] scaled
);

  logic signed [10:0] offset_d, offset_q;
  logic               in_range_d, in_range_q;
  logic [1:0]         shift_d, shift_q;
  logic               zoom_in_d, zoom_in_q;
  logic [9:0]         mag;

  always_comb begin
    offset_d   = $signed({1'b0, coord}) - $signed({1'b0, origin});
    // blanking coordinates are rejected explicitly, independent of the window geometry
    in_range_d = !offset_d[10] && ($unsigned(offset_d) < size) && (32'(coord) < SCR);
    shift_d    = shift;
    zoom_in_d  = zoom_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      offset_q   <= '0;
      in_range_q <= 1'b0;
      shift_q    <= '0;
      zoom_in_q  <= 1'b0;
    end else begin
      offset_q   <= offset_d;
      in_range_q <= in_range_d;
      shift_q    <= shift_d;
      zoom_in_q  <= zoom_in_d;
    end
  end

  always_comb begin
    mag    = offset_q[10] ? '0 : offset_q[9:0];
    scaled = zoom_in_q ? (mag >> shift_q) : (mag << shift_q);
  end

  assign in_range = in_range_q;

endmodule

// File: rtl/zoom_addr_gen.sv
// Maps look-ahead VGA coordinates to centred, zoomed ROM addresses and gates the ROM pixel.
// 2 cycles to address/pix_valid, 3+MEM_LAT to color_out; streaming, no backpressure.
module zoom_addr_gen
  import zoom_pkg::*;
#(
  parameter int         IMG_W    = 160,
  parameter int         IMG_H    = 120,
  parameter int         SCR_W    = 640,
  parameter int         SCR_H    = 480,
  parameter int         MEM_LAT  = 1,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         chaves,
  zoom_addr_gen_if.slave     bus
);

  logic [2:0]         sw_meta_d, sw_meta_q;
  logic [2:0]         sw_s_d, sw_s_q;
  mode_e              mode_d, mode_q;
  logic               frame_start;

  logic [9:0]         org_x, org_y;
  logic [10:0]        size_x, size_y;
  logic [1:0]         shift;
  logic               zoom_in;

  logic               x_in, y_in, in_win;
  logic [9:0]         x_img, y_img;

  logic [ADDR_W-1:0]  address_d, address_q;
  logic               pix_valid_d, pix_valid_q;
  logic [MEM_LAT-1:0] vpipe_d, vpipe_q;
  logic [PIX_W-1:0]   color_out_d, color_out_q;

  // Mode only changes at frame start; stage 1 already sees the newly latched value
  always_comb begin
    sw_meta_d   = chaves;
    sw_s_d      = sw_meta_q;
    frame_start = (bus.next_x == '0) && (bus.next_y == '0);
    mode_d      = frame_start ? decode_mode(sw_s_q) : mode_q;
    size_x      = 11'(win_size(IMG_W, mode_d));
    size_y      = 11'(win_size(IMG_H, mode_d));
    org_x       = 10'(win_origin(SCR_W, IMG_W, mode_d));
    org_y       = 10'(win_origin(SCR_H, IMG_H, mode_d));
    shift       = mode_shift(mode_d);
    zoom_in     = mode_zoom_in(mode_d);
  end

  axis_map #(.SCR(SCR_W)) u_axis_x (
    .clock    (clock),
    .reset    (reset),
    .coord    (bus.next_x),
    .origin   (org_x),
    .size     (size_x),
    .shift    (shift),
    .zoom_in  (zoom_in),
    .in_range (x_in),
    .scaled   (x_img)
  );

  axis_map #(.SCR(SCR_H)) u_axis_y (
    .clock    (clock),
    .reset    (reset),
    .coord    (bus.next_y),
    .origin   (org_y),
    .size     (size_y),
    .shift    (shift),
    .zoom_in  (zoom_in),
    .in_range (y_in),
    .scaled   (y_img)
  );

  always_comb begin
    in_win      = x_in && y_in;
    address_d   = in_win ? ADDR_W'(32'(y_img) * 32'(IMG_W) + 32'(x_img)) : '0;
    pix_valid_d = in_win;
    // valid delay matching the ROM read latency; the top bit falls off the end
    vpipe_d     = MEM_LAT'({vpipe_q, pix_valid_q});
    color_out_d = vpipe_q[MEM_LAT-1] ? bus.mem_q : BG_COLOR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      mode_q      <= MODE_IDENT;
      address_q   <= '0;
      pix_valid_q <= 1'b0;
      vpipe_q     <= '0;
      color_out_q <= BG_COLOR;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_s_q      <= sw_s_d;
      mode_q      <= mode_d;
      address_q   <= address_d;
      pix_valid_q <= pix_valid_d;
      vpipe_q     <= vpipe_d;
      color_out_q <= color_out_d;
    end
  end

  assign bus.address   = address_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.color_out = color_out_q;
  assign bus.mode      = mode_q;

endmodule

// File: tb/tb_zoom_addr_gen.sv
// Directed vector bench for zoom_addr_gen at 160x120 image, 640x480 screen, MEM_LAT=1.
module tb_zoom_addr_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] chaves = 3'b000;

  int n_checks = 0;
  int n_fail   = 0;

  zoom_addr_gen_if bus ();

  zoom_addr_gen #(
    .IMG_W(160), .IMG_H(120), .SCR_W(640), .SCR_H(480), .MEM_LAT(1), .BG_COLOR(8'h00)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .chaves (chaves),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  sw;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        exp_v;
    logic [16:0] exp_a;
    logic [2:0]  exp_mode;
  } vec_t;

  vec_t vecs [19];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_xy(input logic [9:0] x, input logic [9:0] y);
    bus.next_x = x;
    bus.next_y = y;
  endtask

  // Hold switches long enough to pass the synchroniser, then present a frame start
  task automatic latch_mode(input logic [2:0] sw);
    chaves = sw;
    set_xy(10'd5, 10'd5);
    repeat (3) step();
    set_xy(10'd0, 10'd0);
    step();
  endtask

  initial begin
    //          sw      x     y     v   addr      mode
    vecs[0]  = '{3'b000, 10'd240, 10'd180, 1'b1, 17'd0,     3'b000};
    vecs[1]  = '{3'b000, 10'd399, 10'd299, 1'b1, 17'd19199, 3'b000};
    vecs[2]  = '{3'b000, 10'd239, 10'd180, 1'b0, 17'd0,     3'b000};
    vecs[3]  = '{3'b000, 10'd400, 10'd300, 1'b0, 17'd0,     3'b000};
    vecs[4]  = '{3'b000, 10'd700, 10'd520, 1'b0, 17'd0,     3'b000};
    vecs[5]  = '{3'b001, 10'd160, 10'd120, 1'b1, 17'd0,     3'b001};
    vecs[6]  = '{3'b001, 10'd161, 10'd121, 1'b1, 17'd0,     3'b001};
    vecs[7]  = '{3'b001, 10'd162, 10'd122, 1'b1, 17'd161,   3'b001};
    vecs[8]  = '{3'b001, 10'd479, 10'd359, 1'b1, 17'd19199, 3'b001};
    vecs[9]  = '{3'b001, 10'd480, 10'd360, 1'b0, 17'd0,     3'b001};
    vecs[10] = '{3'b010, 10'd0,   10'd0,   1'b1, 17'd0,     3'b010};
    vecs[11] = '{3'b010, 10'd4,   10'd0,   1'b1, 17'd1,     3'b010};
    vecs[12] = '{3'b010, 10'd639, 10'd479, 1'b1, 17'd19199, 3'b010};
    vecs[13] = '{3'b010, 10'd700, 10'd100, 1'b0, 17'd0,     3'b010};
    vecs[14] = '{3'b011, 10'd282, 10'd211, 1'b1, 17'd324,   3'b011};
    vecs[15] = '{3'b011, 10'd279, 10'd210, 1'b0, 17'd0,     3'b011};
    vecs[16] = '{3'b100, 10'd301, 10'd226, 1'b1, 17'd644,   3'b100};
    vecs[17] = '{3'b100, 10'd340, 10'd255, 1'b0, 17'd0,     3'b100};
    vecs[18] = '{3'b111, 10'd240, 10'd180, 1'b1, 17'd0,     3'b000};

    bus.mem_q = 8'h3C;
    set_xy(10'd300, 10'd200);
    chaves = 3'b011;
    repeat (3) step();
    check("reset address",   32'(bus.address),   32'd0);
    check("reset pix_valid", 32'(bus.pix_valid), 32'd0);
    check("reset color_out", 32'(bus.color_out), 32'h00);
    check("reset mode",      32'(bus.mode),      32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      latch_mode(vecs[i].sw);
      set_xy(vecs[i].x, vecs[i].y);
      step();
      set_xy(10'd5, 10'd5);
      step();
      check($sformatf("vec%0d pix_valid", i), 32'(bus.pix_valid), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d address", i),   32'(bus.address),   32'(vecs[i].exp_a));
      check($sformatf("vec%0d mode", i),      32'(bus.mode),      32'(vecs[i].exp_mode));
      if (bus.pix_valid)
        check($sformatf("vec%0d addr in image", i), 32'(bus.address < 17'd19200), 32'd1);
    end

    // Switch change mid-frame must wait for the next frame start
    latch_mode(3'b001);
    chaves = 3'b010;
    set_xy(10'd100, 10'd200);
    repeat (5) step();
    check("mid-frame mode hold", 32'(bus.mode), 32'b001);
    set_xy(10'd0, 10'd0);
    step();
    check("frame-start mode", 32'(bus.mode), 32'b010);
    latch_mode(3'b111);
    check("undefined sw mode", 32'(bus.mode), 32'b000);

    // Colour path: inside the window the ROM byte appears 4 cycles after the coordinate
    bus.mem_q = 8'hA5;
    set_xy(10'd240, 10'd180);
    step();
    set_xy(10'd5, 10'd5);
    repeat (2) step();
    check("color before latency", 32'(bus.color_out), 32'h00);
    step();
    check("color in window", 32'(bus.color_out), 32'hA5);
    set_xy(10'd239, 10'd180);
    step();
    set_xy(10'd5, 10'd5);
    repeat (3) step();
    check("color outside window", 32'(bus.color_out), 32'h00);

    // Reset mid-stream clears the pipe and drops back to IDENT until a frame start
    latch_mode(3'b001);
    set_xy(10'd162, 10'd122);
    step();
    reset = 1'b1;
    step();
    check("midreset pix_valid", 32'(bus.pix_valid), 32'd0);
    check("midreset address",   32'(bus.address),   32'd0);
    check("midreset color",     32'(bus.color_out), 32'h00);
    check("midreset mode",      32'(bus.mode),      32'd0);
    reset = 1'b0;
    set_xy(10'd240, 10'd180);
    step();
    set_xy(10'd5, 10'd5);
    step();
    check("post-reset pix_valid", 32'(bus.pix_valid), 32'd1);
    check("post-reset address",   32'(bus.address),   32'd0);
    check("post-reset mode",      32'(bus.mode),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
